// File: rtl/bram_pixel_reader_if.sv
// BRAM read port plus outgoing pixel stream for bram_pixel_reader.
interface bram_pixel_reader_if;
  logic [31:0] bram_address;
  logic [31:0] bram_data;
  logic [7:0]  pixel_o;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output bram_address, pixel_o, pixel_valid,
    input  bram_data, pixel_ready
  );

  modport slave (
    input  bram_address, pixel_o, pixel_valid,
    output bram_data, pixel_ready
  );
endinterface

// File: rtl/bram_pixel_reader.sv
// Streams a 4-pixels-per-word BRAM image out as one 8-bit pixel per handshake.
//
// state  | meaning
// IDLE   | waiting for start
// FILL   | word 0 read in flight
// STREAM | emitting pixels, prefetching the next word
// DONE   | one-cycle image_done pulse
module bram_pixel_reader #(
  parameter int          IMG_WIDTH  = 28,
  parameter int          IMG_HEIGHT = 28,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  bram_pixel_reader_if.master        bus,
  output logic                       busy,
  output logic                       image_done
);
  localparam int          NPIX     = IMG_WIDTH * IMG_HEIGHT;
  localparam int          NWORD    = (NPIX + 3) / 4;
  localparam logic [15:0] LAST_PIX = 16'(NPIX - 1);
  localparam logic [15:0] WORDS    = 16'(NWORD);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] addr_q;
  logic [31:0] cur_word, pf_word;
  logic [1:0]  byte_idx;
  logic        cur_valid, pf_valid;
  logic        rd_p1, rd_p2;
  logic [15:0] pix_cnt, issue_cnt;

  logic start_acc, issue, hs, word_end, last_hs;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    issue     = 1'b0;
    hs        = cur_valid & bus.pixel_ready;
    last_hs   = hs & (pix_cnt == LAST_PIX);
    word_end  = hs & ((byte_idx == 2'd3) | (pix_cnt == LAST_PIX));
    case (state)
      IDLE: if (start) begin
        state_nx  = FILL;
        start_acc = 1'b1;
      end
      FILL: if (rd_p2) state_nx = STREAM;
      STREAM: begin
        // keep at most one word outstanding beyond the current one
        issue = ~rd_p1 & ~rd_p2 & ~pf_valid & (issue_cnt < WORDS);
        if (last_hs) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= BASE_ADDR;
      cur_word  <= 32'd0;
      pf_word   <= 32'd0;
      byte_idx  <= 2'd0;
      cur_valid <= 1'b0;
      pf_valid  <= 1'b0;
      rd_p1     <= 1'b0;
      rd_p2     <= 1'b0;
      pix_cnt   <= 16'd0;
      issue_cnt <= 16'd0;
    end else begin
      // read data is valid two edges after the address is registered
      rd_p1 <= issue | start_acc;
      rd_p2 <= rd_p1;

      if (hs) pix_cnt <= pix_cnt + 16'd1;

      if (word_end) begin
        byte_idx <= 2'd0;
        if (last_hs) begin
          cur_valid <= 1'b0;
        end else if (pf_valid) begin
          cur_word <= pf_word;
          pf_valid <= 1'b0;
        end else if (rd_p2) begin
          cur_word <= bus.bram_data;
        end else begin
          cur_valid <= 1'b0;
        end
      end else begin
        if (hs) byte_idx <= byte_idx + 2'd1;
        if (rd_p2) begin
          if (!cur_valid) begin
            cur_word  <= bus.bram_data;
            cur_valid <= 1'b1;
            byte_idx  <= 2'd0;
          end else begin
            pf_word  <= bus.bram_data;
            pf_valid <= 1'b1;
          end
        end
      end

      if (issue) begin
        addr_q    <= BASE_ADDR + {14'd0, issue_cnt, 2'b00};
        issue_cnt <= issue_cnt + 16'd1;
      end

      if (start_acc) begin
        addr_q    <= BASE_ADDR;
        issue_cnt <= 16'd1;
        pix_cnt   <= 16'd0;
        cur_valid <= 1'b0;
        pf_valid  <= 1'b0;
        byte_idx  <= 2'd0;
      end
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    bus.pixel_o = cur_word[7:0];
      2'd1:    bus.pixel_o = cur_word[15:8];
      2'd2:    bus.pixel_o = cur_word[23:16];
      default: bus.pixel_o = cur_word[31:24];
    endcase
  end

  assign bus.bram_address = addr_q;
  assign bus.pixel_valid  = cur_valid;
  assign busy             = (state != IDLE);
  assign image_done       = (state == DONE);
endmodule
